ex_mem_stage: RTL and testbench

Parametrised execute stage with an integrated EX/MEM pipeline register. It computes the ALU result, evaluates the full set of RV branch conditions and forms the branch target, then holds everything in a valid/ready output register. An optional iterative multiplier stalls the stage while it runs. It sits between the ID/EX register and the memory stage of the pipelined core.

---
 rtl/ex_pkg.sv | 28 ++
 rtl/ex_alu.sv | 60 ++++++
 rtl/ex_mem_stage.sv | 186 ++++++++++++++++++
 tb/tb_ex_mem_stage.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ex_pkg.sv
// Shared definitions for the execute stage: ALU opcodes, branch conditions and stage states.
package ex_pkg;

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_SLL  = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SRL  = 4'b0101;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_SLT  = 4'b0111;
  localparam logic [3:0] ALU_SLTU = 4'b1000;
  localparam logic [3:0] ALU_SRA  = 4'b1001;
  localparam logic [3:0] ALU_MUL  = 4'b1010;

  localparam logic [2:0] BR_EQ  = 3'b000;
  localparam logic [2:0] BR_NE  = 3'b001;
  localparam logic [2:0] BR_LT  = 3'b100;
  localparam logic [2:0] BR_GE  = 3'b101;
  localparam logic [2:0] BR_LTU = 3'b110;
  localparam logic [2:0] BR_GEU = 3'b111;

  typedef enum logic {
    IDLE     = 1'b0,
    MUL_BUSY = 1'b1
  } ex_state_t;

endpackage

// File: rtl/ex_alu.sv
// Combinational ALU (all single-cycle operations) plus the branch condition comparator.
module ex_alu
  import ex_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [3:0]      i_alu_ctrl,
  input  logic [2:0]      i_br_funct3,
  input  logic [XLEN-1:0] i_a,
  input  logic [XLEN-1:0] i_b,
  output logic [XLEN-1:0] o_result,
  output logic            o_cond
);

  localparam int SHW = $clog2(XLEN);

  logic [SHW-1:0]         w_shamt;
  logic                   w_eq;
  logic                   w_lt;
  logic                   w_ltu;
  logic signed [XLEN-1:0] w_sra;

  assign w_shamt = i_b[SHW-1:0];
  assign w_eq    = (i_a == i_b);
  assign w_lt    = ($signed(i_a) < $signed(i_b));
  assign w_ltu   = (i_a < i_b);
  assign w_sra   = $signed(i_a) >>> w_shamt;

  // The multiply opcode is not handled here; it falls to the zero default like any unknown code.
  always_comb begin
    o_result = '0;
    case (i_alu_ctrl)
      ALU_AND:  o_result = i_a & i_b;
      ALU_OR:   o_result = i_a | i_b;
      ALU_ADD:  o_result = i_a + i_b;
      ALU_SLL:  o_result = i_a << w_shamt;
      ALU_XOR:  o_result = i_a ^ i_b;
      ALU_SRL:  o_result = i_a >> w_shamt;
      ALU_SUB:  o_result = i_a - i_b;
      ALU_SLT:  o_result = {{(XLEN-1){1'b0}}, w_lt};
      ALU_SLTU: o_result = {{(XLEN-1){1'b0}}, w_ltu};
      ALU_SRA:  o_result = w_sra;
      default:  o_result = '0;
    endcase
  end

  always_comb begin
    o_cond = 1'b0;
    case (i_br_funct3)
      BR_EQ:   o_cond = w_eq;
      BR_NE:   o_cond = !w_eq;
      BR_LT:   o_cond = w_lt;
      BR_GE:   o_cond = !w_lt;
      BR_LTU:  o_cond = w_ltu;
      BR_GEU:  o_cond = !w_ltu;
      default: o_cond = 1'b0;
    endcase
  end

endmodule

// File: rtl/ex_mem_stage.sv
// Execute stage with integrated EX/MEM valid/ready register.
// Define EX_MUL_EN to compile in the iterative shift-add multiplier (ALU code 1010).
module ex_mem_stage
  import ex_pkg::*;
#(
  parameter int XLEN = 64,
  parameter int REGW = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      alu_ctrl,
  input  logic [2:0]      br_funct3,
  input  logic [XLEN-1:0] rd1,
  input  logic [XLEN-1:0] rd2,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] imm,
  input  logic            branch,
  input  logic            memwrite,
  input  logic            memread,
  input  logic            memtoreg,
  input  logic            regwrite,
  input  logic [REGW-1:0] write_reg,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] alu_result_out,
  output logic [XLEN-1:0] store_data_out,
  output logic [XLEN-1:0] pc_target_out,
  output logic            taken_out,
  output logic [REGW-1:0] write_reg_out,
  output logic            branch_out,
  output logic            memwrite_out,
  output logic            memread_out,
  output logic            memtoreg_out,
  output logic            regwrite_out
);

  logic [XLEN-1:0] w_alu_result;
  logic [XLEN-1:0] w_pc_target;
  logic [XLEN-1:0] w_mul_product;
  logic            w_cond;
  logic            w_taken;
  logic            w_accept;
  logic            w_is_mul;
  logic            w_mul_done;
  logic            w_in_ready;

  logic            r_out_valid;
  logic [XLEN-1:0] r_alu_result;
  logic [XLEN-1:0] r_store_data;
  logic [XLEN-1:0] r_pc_target;
  logic            r_taken;
  logic [REGW-1:0] r_write_reg;
  logic            r_branch;
  logic            r_memwrite;
  logic            r_memread;
  logic            r_memtoreg;
  logic            r_regwrite;

  ex_alu #(.XLEN(XLEN)) u_alu (
    .i_alu_ctrl  (alu_ctrl),
    .i_br_funct3 (br_funct3),
    .i_a         (rd1),
    .i_b         (rd2),
    .o_result    (w_alu_result),
    .o_cond      (w_cond)
  );

  assign w_pc_target = pc + (imm << 1);
  assign w_taken     = branch && w_cond;
  assign w_accept    = in_valid && w_in_ready && !flush;
  assign in_ready    = w_in_ready;

`ifdef EX_MUL_EN
  localparam int CNTW = $clog2(XLEN);

  ex_state_t       r_state;
  ex_state_t       w_state_next;
  logic [XLEN-1:0] r_mcand;
  logic [XLEN-1:0] r_mplier;
  logic [XLEN-1:0] r_acc;
  logic [CNTW-1:0] r_cnt;

  assign w_is_mul      = (alu_ctrl == ALU_MUL);
  assign w_in_ready    = (r_state == IDLE) && (!r_out_valid || out_ready);
  assign w_mul_product = r_acc + (r_mplier[0] ? r_mcand : '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_mul_done   = 1'b0;
    if (flush) begin
      w_state_next = IDLE;
    end else begin
      case (r_state)
        IDLE:     if (w_accept && w_is_mul) w_state_next = MUL_BUSY;
        MUL_BUSY: if (r_cnt == CNTW'(XLEN-1)) begin
                    w_state_next = IDLE;
                    w_mul_done   = 1'b1;
                  end
        default:  w_state_next = IDLE;
      endcase
    end
  end

  // One multiplier bit per cycle; the final step's partial sum goes straight to the output register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
    end else if (w_accept && w_is_mul) begin
      r_mcand  <= rd1;
      r_mplier <= rd2;
      r_acc    <= '0;
      r_cnt    <= '0;
    end else if (r_state == MUL_BUSY) begin
      r_acc    <= w_mul_product;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_cnt    <= r_cnt + 1'b1;
    end
  end
`else
  assign w_is_mul      = 1'b0;
  assign w_in_ready    = !r_out_valid || out_ready;
  assign w_mul_done    = 1'b0;
  assign w_mul_product = '0;
`endif

  // A multiply accept loads the side fields now (register is empty) and the product later.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid  <= 1'b0;
      r_alu_result <= '0;
      r_store_data <= '0;
      r_pc_target  <= '0;
      r_taken      <= 1'b0;
      r_write_reg  <= '0;
      r_branch     <= 1'b0;
      r_memwrite   <= 1'b0;
      r_memread    <= 1'b0;
      r_memtoreg   <= 1'b0;
      r_regwrite   <= 1'b0;
    end else if (flush) begin
      r_out_valid  <= 1'b0;
    end else if (w_accept) begin
      r_out_valid  <= !w_is_mul;
      r_alu_result <= w_alu_result;
      r_store_data <= rd2;
      r_pc_target  <= w_pc_target;
      r_taken      <= w_taken;
      r_write_reg  <= write_reg;
      r_branch     <= branch;
      r_memwrite   <= memwrite;
      r_memread    <= memread;
      r_memtoreg   <= memtoreg;
      r_regwrite   <= regwrite;
    end else if (w_mul_done) begin
      r_out_valid  <= 1'b1;
      r_alu_result <= w_mul_product;
    end else if (out_ready) begin
      r_out_valid  <= 1'b0;
    end
  end

  assign out_valid      = r_out_valid;
  assign alu_result_out = r_alu_result;
  assign store_data_out = r_store_data;
  assign pc_target_out  = r_pc_target;
  assign taken_out      = r_taken;
  assign write_reg_out  = r_write_reg;
  assign branch_out     = r_branch;
  assign memwrite_out   = r_memwrite;
  assign memread_out    = r_memread;
  assign memtoreg_out   = r_memtoreg;
  assign regwrite_out   = r_regwrite;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Scoreboard bench for ex_mem_stage: expected records queued on accept, compared when consumed.
// Define EX_MUL_EN for both bench and RTL to exercise the multiplier steps.
`timescale 1ns/1ps
module tb_ex_mem_stage;
  import ex_pkg::*;

  localparam int XLEN = 64;
  localparam int REGW = 5;

  logic            clk = 1'b0;
  logic            rst, flush, inValid, inReady, outValid, outReady;
  logic [3:0]      aluCtrl;
  logic [2:0]      brFunct3;
  logic [XLEN-1:0] rd1, rd2, pcIn, immIn;
  logic            branchIn, memwriteIn, memreadIn, memtoregIn, regwriteIn;
  logic [REGW-1:0] writeRegIn;
  logic [XLEN-1:0] aluResultOut, storeDataOut, pcTargetOut;
  logic            takenOut, branchOut, memwriteOut, memreadOut, memtoregOut, regwriteOut;
  logic [REGW-1:0] writeRegOut;

  typedef struct packed {
    logic [XLEN-1:0] alu;
    logic [XLEN-1:0] store;
    logic [XLEN-1:0] target;
    logic            taken;
    logic [REGW-1:0] wr;
    logic            br, mw, mr, mt, rw;
  } outRec_t;

  outRec_t q[$];
  outRec_t observed;
  int nCompared = 0;
  int nMismatched = 0;
  int busyCycles;

  always #5 clk = ~clk;

  ex_mem_stage #(.XLEN(XLEN), .REGW(REGW)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(inValid), .in_ready(inReady),
    .alu_ctrl(aluCtrl), .br_funct3(brFunct3), .rd1(rd1), .rd2(rd2), .pc(pcIn), .imm(immIn),
    .branch(branchIn), .memwrite(memwriteIn), .memread(memreadIn), .memtoreg(memtoregIn),
    .regwrite(regwriteIn), .write_reg(writeRegIn), .out_valid(outValid), .out_ready(outReady),
    .alu_result_out(aluResultOut), .store_data_out(storeDataOut), .pc_target_out(pcTargetOut),
    .taken_out(takenOut), .write_reg_out(writeRegOut), .branch_out(branchOut),
    .memwrite_out(memwriteOut), .memread_out(memreadOut), .memtoreg_out(memtoregOut),
    .regwrite_out(regwriteOut)
  );

  assign observed = {aluResultOut, storeDataOut, pcTargetOut, takenOut, writeRegOut,
                     branchOut, memwriteOut, memreadOut, memtoregOut, regwriteOut};

  task automatic checkEq(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    nCompared++;
    assert (obs === exp) else begin
      nMismatched++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference behaviour written straight from the instruction semantics.
  function automatic outRec_t model();
    outRec_t e;
    logic c;
    e.alu = '0;
    case (aluCtrl)
      4'b0000: e.alu = rd1 & rd2;
      4'b0001: e.alu = rd1 | rd2;
      4'b0010: e.alu = rd1 + rd2;
      4'b0011: e.alu = rd1 << rd2[5:0];
      4'b0100: e.alu = rd1 ^ rd2;
      4'b0101: e.alu = rd1 >> rd2[5:0];
      4'b0110: e.alu = rd1 - rd2;
      4'b0111: e.alu = ($signed(rd1) < $signed(rd2)) ? 64'd1 : 64'd0;
      4'b1000: e.alu = (rd1 < rd2) ? 64'd1 : 64'd0;
      4'b1001: e.alu = $signed(rd1) >>> rd2[5:0];
`ifdef EX_MUL_EN
      4'b1010: e.alu = rd1 * rd2;
`endif
      default: e.alu = '0;
    endcase
    case (brFunct3)
      3'b000:  c = (rd1 == rd2);
      3'b001:  c = (rd1 != rd2);
      3'b100:  c = ($signed(rd1) < $signed(rd2));
      3'b101:  c = ($signed(rd1) >= $signed(rd2));
      3'b110:  c = (rd1 < rd2);
      3'b111:  c = (rd1 >= rd2);
      default: c = 1'b0;
    endcase
    e.store  = rd2;
    e.target = pcIn + {immIn[XLEN-2:0], 1'b0};
    e.taken  = branchIn && c;
    e.wr     = writeRegIn;
    e.br     = branchIn;
    e.mw     = memwriteIn;
    e.mr     = memreadIn;
    e.mt     = memtoregIn;
    e.rw     = regwriteIn;
    return e;
  endfunction

  task automatic applyStimulus(input logic [3:0] ctrl, input logic [2:0] f3,
                               input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                               input logic [XLEN-1:0] p, input logic [XLEN-1:0] im,
                               input logic [4:0] ctl, input logic [REGW-1:0] wr);
    inValid = 1'b1;
    aluCtrl = ctrl; brFunct3 = f3; rd1 = a; rd2 = b; pcIn = p; immIn = im;
    {branchIn, memwriteIn, memreadIn, memtoregIn, regwriteIn} = ctl;
    writeRegIn = wr;
  endtask

  // One clock: score what downstream consumes, queue what the stage accepts, then step.
  task automatic checkOutput(input string tag);
    outRec_t head;
    @(negedge clk);
    if (outValid && outReady) begin
      checkEq({tag, " queue"}, 256'(q.size() > 0), 256'(1));
      if (q.size() > 0) begin
        head = q.pop_front();
        checkEq(tag, observed, head);
      end
    end
    if (flush) q.delete();
    if (inValid && inReady && !flush) q.push_back(model());
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst = 1'b1; flush = 1'b0; inValid = 1'b0; outReady = 1'b0;
    aluCtrl = '0; brFunct3 = '0; rd1 = '0; rd2 = '0; pcIn = '0; immIn = '0;
    {branchIn, memwriteIn, memreadIn, memtoregIn, regwriteIn} = '0;
    writeRegIn = '0;
    #12;
    checkEq("reset fields", observed, '0);
    checkEq("reset out_valid", outValid, 0);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    checkEq("in_ready after reset", inReady, 1);

    // Basic ADD, one-cycle latency.
    outReady = 1'b1;
    applyStimulus(ALU_ADD, 3'b010, 64'd5, 64'd7, 64'h0, 64'h0, 5'b00001, 5'd3);
    checkOutput("add");
    checkEq("add result", aluResultOut, 64'd12);
    checkEq("add valid", outValid, 1);

    // Back-to-back issue across every opcode.
    for (int r = 0; r < 2; r++) begin
      for (int op = 0; op < 16; op++) begin
`ifdef EX_MUL_EN
        if (op == 10) continue;
`endif
        applyStimulus(4'(op), 3'(op), {$urandom, $urandom}, {$urandom, $urandom},
                      {$urandom, $urandom}, {$urandom, $urandom}, 5'($urandom), 5'($urandom));
        checkOutput("stream");
        checkEq("stream valid", outValid, 1);
      end
    end

    // Branches.
    applyStimulus(ALU_ADD, BR_LT, {XLEN{1'b1}}, 64'd1, 64'h100, 64'h10, 5'b10000, 5'd0);
    checkOutput("blt");
    checkEq("blt taken", takenOut, 1);
    checkEq("blt target", pcTargetOut, 64'h120);
    applyStimulus(ALU_ADD, BR_LTU, {XLEN{1'b1}}, 64'd1, 64'h100, 64'h10, 5'b10000, 5'd0);
    checkOutput("bltu");
    checkEq("bltu taken", takenOut, 0);
    for (int f = 0; f < 8; f++) begin
      applyStimulus(ALU_SUB, 3'(f), 64'd9, (f % 2 == 0) ? 64'd9 : 64'hFFFF_0000_0000_0000,
                    64'hFFFF_FFFF_FFFF_FFF0, 64'h20, 5'b10000, 5'd1);
      checkOutput("branch sweep");
    end

    // Backpressure: hold for ten cycles, then drain and accept together.
    applyStimulus(ALU_XOR, 3'b000, 64'hA5A5, 64'h0F0F, 64'h40, 64'h4, 5'b01010, 5'd9);
    checkOutput("pre-hold");
    outReady = 1'b0;
    applyStimulus(ALU_OR, 3'b000, 64'h1234, 64'h8000, 64'h80, 64'h8, 5'b00101, 5'd17);
    for (int i = 0; i < 10; i++) begin
      checkOutput("hold");
      checkEq("hold in_ready", inReady, 0);
      checkEq("hold depth", 256'(q.size()), 256'(1));
      checkEq("hold fields", observed, q[0]);
    end
    outReady = 1'b1;
    checkOutput("drain");
    checkEq("reload valid", outValid, 1);
    checkEq("reload fields", observed, q[0]);
    inValid = 1'b0;
    repeat (2) checkOutput("idle");

    // Flush with a simultaneous accept, then flush of a held result.
    applyStimulus(ALU_ADD, 3'b000, 64'd1, 64'd1, 64'd0, 64'd0, 5'b00001, 5'd4);
    flush = 1'b1;
    checkOutput("flush accept");
    flush = 1'b0; inValid = 1'b0;
    checkEq("flush accept valid", outValid, 0);
    outReady = 1'b0;
    applyStimulus(ALU_ADD, 3'b000, 64'd2, 64'd2, 64'd0, 64'd0, 5'b00001, 5'd5);
    checkOutput("pre-flush");
    inValid = 1'b0; flush = 1'b1;
    checkOutput("flush held");
    flush = 1'b0;
    checkEq("flush held valid", outValid, 0);
    outReady = 1'b1;

`ifdef EX_MUL_EN
    applyStimulus(ALU_MUL, 3'b000, 64'hFFFF_FFFF, 64'd3, 64'd0, 64'd0, 5'b00001, 5'd6);
    checkOutput("mul issue");
    inValid = 1'b0;
    busyCycles = 0;
    for (int i = 0; i < 200 && !outValid; i++) begin
      if (!inReady) busyCycles++;
      checkOutput("mul wait");
    end
    checkEq("mul busy cycles", 256'(busyCycles), 256'(64));
    checkEq("mul result", aluResultOut, 64'h2_FFFF_FFFD);
    checkOutput("mul");
    applyStimulus(ALU_MUL, 3'b000, 64'd11, 64'd13, 64'd0, 64'd0, 5'b00001, 5'd7);
    checkOutput("mul2 issue");
    inValid = 1'b0;
    repeat (9) checkOutput("mul2 busy");
    flush = 1'b1;
    checkOutput("mul2 flush");
    flush = 1'b0;
    checkEq("mul flush ready", inReady, 1);
    for (int i = 0; i < 70; i++) begin
      checkOutput("mul2 after");
      if (outValid) break;
    end
    checkEq("mul flush no output", outValid, 0);
`endif

    // Asynchronous reset while a result is held.
    outReady = 1'b0;
    applyStimulus(ALU_ADD, 3'b000, 64'd100, 64'd23, 64'h200, 64'h3, 5'b11111, 5'd31);
    checkOutput("pre-reset");
    inValid = 1'b0;
    #2 rst = 1'b1;
    #1;
    checkEq("async reset fields", observed, '0);
    checkEq("async reset valid", outValid, 0);
    q.delete();
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    checkEq("ready after reset", inReady, 1);

    outReady = 1'b1;
    applyStimulus(ALU_SRA, 3'b000, 64'h8000_0000_0000_0000, 64'd63, 64'd0, 64'd0, 5'b00001, 5'd2);
    checkOutput("sra");
    checkEq("sra result", aluResultOut, {XLEN{1'b1}});

    inValid = 1'b0;
    repeat (3) checkOutput("final drain");
    checkEq("queue drained", 256'(q.size()), 256'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
